// File: rtl/vga_text_pkg.sv
// Shared timing constants, pipeline sideband type and cell addressing for the VGA text console.
package vga_text_pkg;

    localparam int COLS     = 80;
    localparam int ROWS     = 30;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 16;
    localparam int CELLS    = COLS * ROWS;

    localparam int H_VISIBLE = COLS * GLYPH_W;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = ROWS * GLYPH_H;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic       visible;
        logic       hsync;
        logic       vsync;
        logic       first;
        logic [2:0] xbit;
    } scan_tag_t;

    // row*80 + col built from two shifts so no multiplier is inferred
    function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
        logic [11:0] r;
        r = {7'd0, row};
        return (r << 6) + (r << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/vga_text_console_font_rom.sv
// 4096x8 glyph ROM, address {code, glyph row}, one registered read port.
// Holds the code page 437 glyphs used by the console; codes not listed read as blank.
module font_rom
    import vga_text_pkg::*;
(
    input  logic        clock,
    input  logic [11:0] addr,
    output logic [7:0]  data
);

    function automatic logic [7:0] glyph_row(input logic [7:0] code, input logic [3:0] row);
        logic [GLYPH_W*GLYPH_H-1:0] bits;
        case (code)
            8'h41:   bits = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
            8'h42:   bits = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
            8'hDB:   bits = {16{8'hFF}};
            default: bits = '0;
        endcase
        // row 0 is the most significant byte
        return bits[{~row, 3'b111} -: 8];
    endfunction

    always_ff @(posedge clock) begin
        data <= glyph_row(addr[11:4], addr[3:0]);
    end

endmodule

// File: rtl/vga_text_console.sv
// 80x30 character buffer scanned out as 640x480@60 VGA through an 8x16 font, 3-cycle pixel pipeline.
module vga_text_console
    import vga_text_pkg::*;
#(
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] console_addr,
    input  logic        console_write,
    input  logic [7:0]  console_data,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    function automatic logic [11:0] pixel_color(input logic on, input logic visible);
        if (!visible) return 12'h000;
        return on ? FG_COLOR : BG_COLOR;
    endfunction

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    scan_tag_t   tag_p0, tag_p1, tag_p2;
    logic [11:0] rd_addr_p0;
    logic [7:0]  code_p1;
    logic [3:0]  yrow_p1;
    logic [7:0]  row_p2;
    logic        vld_p1, vld_p2;
    logic        hsync_p3, vsync_p3, first_p3;
    logic [11:0] rgb_p3;
    logic [7:0]  char_mem [CELLS];

    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Stage 0: decode the counters and address the character buffer
    always_comb begin
        tag_p0.visible = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
        tag_p0.hsync   = !((h_cnt >= 10'(H_VISIBLE + H_FP)) &&
                           (h_cnt <  10'(H_VISIBLE + H_FP + H_SYNC)));
        tag_p0.vsync   = !((v_cnt >= 10'(V_VISIBLE + V_FP)) &&
                           (v_cnt <  10'(V_VISIBLE + V_FP + V_SYNC)));
        tag_p0.first   = (h_cnt == '0) && (v_cnt == '0);
        tag_p0.xbit    = h_cnt[2:0];
        rd_addr_p0     = tag_p0.visible ? cell_addr(v_cnt[8:4], h_cnt[9:3]) : '0;
    end

    // Non-blocking read alongside the write gives read-first behaviour on a collision
    always_ff @(posedge clock) begin
        if (console_write && (console_addr < 12'(CELLS))) begin
            char_mem[console_addr] <= console_data;
        end
        code_p1 <= char_mem[rd_addr_p0];
    end

    // Stage 1: character code valid, look up the glyph row
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= 1'b1;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clock) begin
        tag_p1  <= tag_p0;
        yrow_p1 <= v_cnt[3:0];
        tag_p2  <= tag_p1;
    end

    font_rom u_font_rom (
        .clock (clock),
        .addr  ({code_p1, yrow_p1}),
        .data  (row_p2)
    );

    // Stage 2: glyph row valid, pick the pixel and register the pins
    always_ff @(posedge clock) begin
        if (reset || !vld_p2) begin
            hsync_p3 <= 1'b1;
            vsync_p3 <= 1'b1;
            first_p3 <= 1'b0;
            rgb_p3   <= 12'h000;
        end else begin
            hsync_p3 <= tag_p2.hsync;
            vsync_p3 <= tag_p2.vsync;
            first_p3 <= tag_p2.first;
            rgb_p3   <= pixel_color(row_p2[3'd7 - tag_p2.xbit], tag_p2.visible);
        end
    end

    assign vga_hsync   = hsync_p3;
    assign vga_vsync   = vsync_p3;
    assign frame_start = first_p3;
    assign vga_r       = rgb_p3[11:8];
    assign vga_g       = rgb_p3[7:4];
    assign vga_b       = rgb_p3[3:0];

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: cycle-accurate screen model plus directed glyph, sync and reset checks.
module tb_vga_text_console;

    localparam logic [11:0] FG = 12'hFC3;
    localparam logic [11:0] BG = 12'h125;
    localparam logic [14:0] IDLE = {1'b1, 1'b1, 1'b0, 12'h000};
    localparam int FRAME  = 800 * 525;
    localparam int RD_T   = FRAME + 100 * 800 + 160;
    localparam int RST_AT = FRAME + 200 * 800 + 300;
    localparam logic [7:0] GLYPH_A [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                            8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] GLYPH_B [16] = '{8'h00, 8'h00, 8'hFC, 8'h66, 8'h66, 8'h66, 8'h7C, 8'h66,
                                            8'h66, 8'h66, 8'h66, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] DATA_SET [4] = '{8'h00, 8'h41, 8'h42, 8'hDB};

    logic        clock;
    logic        reset;
    logic [11:0] console_addr;
    logic        console_write;
    logic [7:0]  console_data;
    logic        vga_hsync, vga_vsync, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;

    vga_text_console #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (
        .clock         (clock),
        .reset         (reset),
        .console_addr  (console_addr),
        .console_write (console_write),
        .console_data  (console_data),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .frame_start   (frame_start)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cnt = 0;
    int          phase = 0;
    logic        live = 1'b0;
    logic [14:0] exp_out = IDLE;
    logic [14:0] pipe [3];
    logic [7:0]  mem [2400];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic finish_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cnt, got, exp);
            if (n_bad >= 40) finish_run();
        end
    endtask

    function automatic logic [7:0] font_row(input logic [7:0] code, input int r);
        case (code)
            8'h41:   return GLYPH_A[r];
            8'h42:   return GLYPH_B[r];
            8'hDB:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    // What the screen should show at scan position k (counted from the last reset)
    function automatic logic [14:0] pixel_of(input int k);
        int h, v;
        logic vis, hs, vs, fs, on;
        logic [7:0]  code, row;
        logic [11:0] rgb;
        h    = k % 800;
        v    = (k / 800) % 525;
        vis  = (h < 640) && (v < 480);
        hs   = !((h >= 656) && (h < 752));
        vs   = !((v >= 490) && (v < 492));
        fs   = (h == 0) && (v == 0);
        code = 8'h00;
        if (vis) code = mem[(v / 16) * 80 + h / 8];
        row  = font_row(code, v % 16);
        on   = row[7 - h % 8];
        rgb  = !vis ? 12'h000 : (on ? FG : BG);
        return {hs, vs, fs, rgb};
    endfunction

    // Reference model: the cell is sampled before any write in the same cycle; pins lag by 3 cycles
    initial begin
        for (int i = 0; i < 2400; i++) mem[i] = 8'h00;
        for (int i = 0; i < 3; i++) pipe[i] = IDLE;
        forever begin
            @(posedge clock);
            if (reset) begin
                for (int i = 0; i < 3; i++) pipe[i] = IDLE;
                exp_out = IDLE;
                cnt     = 0;
                live    = 1'b1;
            end else begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = pixel_of(cnt);
                exp_out = pipe[2];
                cnt++;
            end
            if (console_write && (console_addr < 12'd2400)) mem[console_addr] = console_data;
        end
    end

    // Output monitor
    initial begin
        logic [14:0] got;
        logic [11:0] rgb;
        logic prev_hs, prev_vs, fs_seen;
        int pix, hs_run, vs_run, last_hfall, last_fs, fg_cnt;
        prev_hs = 1'b1; prev_vs = 1'b1; fs_seen = 1'b0;
        hs_run = 0; vs_run = 0; last_hfall = -1; last_fs = 0; fg_cnt = 0;
        forever begin
            @(negedge clock);
            if (live) begin
                got = {vga_hsync, vga_vsync, frame_start, vga_r, vga_g, vga_b};
                rgb = got[11:0];
                check_val("pixel", 32'(got), 32'(exp_out));
                if (cnt < 3) begin
                    check_val("rst_out", 32'(got), 32'(IDLE));
                    prev_hs = 1'b1; prev_vs = 1'b1; fs_seen = 1'b0;
                    hs_run = 0; vs_run = 0; last_hfall = -1;
                end else begin
                    pix = cnt - 3;
                    if (prev_hs && !got[14]) begin
                        check_val("hsync_fall_h", pix % 800, 656);
                        if (last_hfall >= 0) check_val("hsync_period", cnt - last_hfall, 800);
                        last_hfall = cnt;
                        hs_run = 0;
                    end
                    if (!got[14]) hs_run++;
                    if (!prev_hs && got[14]) check_val("hsync_low", hs_run, 96);
                    if (prev_vs && !got[13]) begin
                        check_val("vsync_fall_pix", pix % FRAME, 490 * 800);
                        vs_run = 0;
                    end
                    if (!got[13]) vs_run++;
                    if (!prev_vs && got[13]) check_val("vsync_low", vs_run, 2 * 800);
                    if (got[12]) begin
                        if (!fs_seen) check_val("fs_first", cnt, 3);
                        else check_val("fs_period", cnt - last_fs, FRAME);
                        fs_seen = 1'b1;
                        last_fs = cnt;
                    end
                    prev_hs = got[14];
                    prev_vs = got[13];
                    if (phase == 1) begin
                        if (pix >= 1600 && pix <= 1607)
                            check_val("glyph_cell0", 32'(rgb), 32'((pix == 1603) ? FG : BG));
                        if (pix >= 471 * 800 + 632 && pix <= 471 * 800 + 639)
                            check_val("glyph_last", 32'(rgb), 32'((pix < 471 * 800 + 639) ? FG : BG));
                        if (pix < FRAME && rgb == FG) fg_cnt++;
                        if (pix == FRAME - 1) check_val("frame1_fg", fg_cnt, 78);
                        if (pix == RD_T) check_val("read_first_old", 32'(rgb), 32'(BG));
                        if (pix == RD_T + 1) check_val("read_first_new", 32'(rgb), 32'(FG));
                    end else if (phase == 2) begin
                        if (pix >= 1600 && pix <= 1607)
                            check_val("glyph_after_rst", 32'(rgb), 32'((pix == 1603) ? FG : BG));
                        if (pix == 20 * 800) check_val("write_in_rst_x0", 32'(rgb), 32'(BG));
                        if (pix == 20 * 800 + 1) check_val("write_in_rst_x1", 32'(rgb), 32'(FG));
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [11:0] a;
        reset = 1'b1;
        console_write = 1'b0;
        console_addr = '0;
        console_data = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            console_write = 1'b1;
            case (i)
                0: begin console_addr = 12'd0;    console_data = 8'h41; end
                1: begin console_addr = 12'd2399; console_data = 8'h41; end
                2: begin console_addr = 12'd2400; console_data = 8'hFF; end
                default: begin console_addr = 12'd4095; console_data = 8'hFF; end
            endcase
        end
        @(negedge clock);
        reset = 1'b0;
        console_write = 1'b0;
        phase = 1;
        while (cnt != FRAME) @(negedge clock);
        while (cnt != RST_AT) begin
            if (cnt == RD_T) begin
                console_write = 1'b1; console_addr = 12'd500; console_data = 8'hDB;
            end else if ($urandom_range(0, 1) == 1) begin
                a = 12'($urandom_range(0, 4095));
                if (a == 12'd0 || a == 12'd80 || a == 12'd500 || a == 12'd2399) a = a + 12'd1;
                console_write = 1'b1;
                console_addr  = a;
                console_data  = DATA_SET[$urandom_range(0, 3)];
            end else begin
                console_write = 1'b0;
            end
            @(negedge clock);
        end
        reset = 1'b1;
        console_write = 1'b1; console_addr = 12'd80; console_data = 8'h42;
        phase = 2;
        @(negedge clock);
        reset = 1'b0;
        console_write = 1'b0;
        while (cnt != 21 * 800) @(negedge clock);
        phase = 3;
        finish_run();
    end

    initial begin
        #(10 * 700000);
        check_val("timeout", 32'(phase), 32'd3);
        finish_run();
    end

endmodule
